hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of data-memory wait cycles before the error flag sets.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID.
REQ-006 use_rs1_ID, use_rs2_ID  in  1 each  the ID instruction actually reads rs1/rs2.
REQ-007 rd_EX  in  5  destination register of the instruction in EX.
REQ-008 mem_read_EX  in  1  the EX instruction is a load (WB_sel=1).
REQ-009 branch_taken_EX  in  1  the branch or jump resolved in EX is taken.
REQ-010 mem_req_MEM  in  1  the MEM-stage instruction is accessing data memory.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 cnt_clr  in  1  synchronous clear of both counters.
REQ-013 stall_IF, stall_ID  out  1 each  hold the PC and IF/ID registers.
REQ-014 bubble_EX  out  1  load ID/EX with a nop.
REQ-015 flush_IF_ID, flush_ID_EX  out  1 each  squash the wrong-path instructions.
REQ-016 freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
REQ-017 mem_timeout  out  1  sticky error flag.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 SHALL implement a 2-state FSM with states RUN and MEM_WAIT.
REQ-020 RUN->MEM_WAIT when mem_req_MEM=1 and mem_ready=0; MEM_WAIT->RUN in the cycle mem_ready=1.
REQ-021 freeze SHALL be 1 combinationally whenever (state=RUN, mem_req_MEM=1, mem_ready=0) or (state=MEM_WAIT, mem_ready=0); a zero-wait access SHALL produce no freeze.
REQ-022 While freeze=1, stall_IF, stall_ID, bubble_EX, flush_IF_ID and flush_ID_EX SHALL all be 0.
REQ-023 Load-use condition: mem_read_EX=1, rd_EX!=0, and rd_EX matches rs1_ID (with use_rs1_ID=1) or rs2_ID (with use_rs2_ID=1).
REQ-024 On load-use with freeze=0 and branch_taken_EX=0, stall_IF, stall_ID and bubble_EX SHALL all be 1 for exactly that cycle; there is one cycle of penalty, after which forwarding supplies the data.
REQ-025 On branch_taken_EX=1 with freeze=0, flush_IF_ID and flush_ID_EX SHALL be 1 in that cycle.
REQ-026 A flush SHALL take priority over a simultaneous load-use; stall_IF, stall_ID and bubble_EX SHALL then be 0.
REQ-027 A branch taken while frozen SHALL flush in the first cycle freeze=0, because the EX stage is held and the input therefore persists.
REQ-028 Wait counter: reset to 0 on entry to MEM_WAIT; increment each MEM_WAIT cycle; saturate at TIMEOUT.
REQ-029 mem_timeout SHALL set when the wait counter reaches TIMEOUT with mem_ready=0, and SHALL clear only on reset.
REQ-030 stall_cnt SHALL increment by 1 in each cycle where stall_ID=1 or freeze=1.
REQ-031 flush_cnt SHALL increment by 1 in each cycle where flush_IF_ID=1.
REQ-032 Both counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-033 cnt_clr SHALL take precedence over increment in the same cycle.
REQ-034 All control outputs SHALL be combinational from the current inputs and state, with zero latency; the counters and mem_timeout SHALL be registered, updating one cycle after the event.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-036 While rst_n=0, all combinational control outputs SHALL be 0.
REQ-037 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release the FSM is in RUN.

Structure
REQ-038 Package hazard_pkg SHALL hold the FSM state type (RUN, MEM_WAIT) and the register-zero constant.
REQ-039 Sub-module sat_counter (parameter W; ports clr, inc, count) SHALL be instantiated twice, once for each performance counter.

Verification
REQ-040 lw x5 in EX with rs1_ID=5 and use_rs1_ID=1 -> stall_IF, stall_ID and bubble_EX are 1 for one cycle; stall_cnt=1 on the following cycle.
REQ-041 Load-use with rd_EX=0 -> no stall; also rs2_ID matching with use_rs2_ID=0 -> no stall.
REQ-042 branch_taken_EX=1 together with load-use -> both flushes are 1 and stall_ID=0; flush_cnt=1 on the following cycle.
REQ-043 mem_req_MEM=1 with mem_ready low for 3 cycles, then high -> freeze is 1 for exactly 3 cycles; a pending branch_taken_EX flushes in the 4th cycle; stall_cnt=3.
REQ-044 TIMEOUT=4 with mem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays set; rst_n pulsed low mid-wait -> state=RUN and all counters are 0.
REQ-045 CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15; cnt_clr asserted during an increment -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes, data-memory
// wait freezes with a sticky timeout, and saturating stall/flush counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_e           fsm_state
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    state_e            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              frozen, load_use, flush, stall, timeout_hit;

    assign fsm_state = state;

    // Handshake: an access completes in the cycle mem_ready=1; until then
    // the whole pipeline is held, including the cycle the request first appears.
    always_comb begin
        state_next = state;
        frozen     = 1'b0;
        case (state)
            RUN: begin
                frozen = mem_req_MEM && !mem_ready;
                if (frozen) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                frozen = !mem_ready;
                if (mem_ready) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        load_use = mem_read_EX && (rd_EX != REG_ZERO) &&
                   ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                    (use_rs2_ID && (rs2_ID == rd_EX)));
        flush    = !frozen && branch_taken_EX;
        stall    = !frozen && !branch_taken_EX && load_use;
    end

    // Outputs are forced low while reset is held.
    assign freeze      = rst_n && frozen;
    assign stall_IF    = rst_n && stall;
    assign stall_ID    = rst_n && stall;
    assign bubble_EX   = rst_n && stall;
    assign flush_IF_ID = rst_n && flush;
    assign flush_ID_EX = rst_n && flush;

    always_comb begin
        wait_next = wait_cnt;
        if (state == RUN) begin
            wait_next = '0;
        end else if (!mem_ready && (wait_cnt != TIMEOUT_V)) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
        timeout_hit = (state == MEM_WAIT) && !mem_ready && (wait_next == TIMEOUT_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (timeout_hit) mem_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall_ID || freeze),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flush_IF_ID),
        .count (flush_cnt)
    );

endmodule
